code_tracker: RTL
=================

CODE_TRACKER -- requirements
Module: code_tracker

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4, the vote threshold of the up/down filter (range 2..15).
REQ-002 SHALL have parameter LOCK_CNT, default 16, the number of consecutive step-free PD strobes needed to declare lock (range 2..255).
REQ-003 SHALL have port CLK_exit, input, 1 bit: the single block clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port SAR_done, input, 1 bit: one-cycle pulse indicating that SAR_Q holds the finished binary-search code.
REQ-006 SHALL have port SAR_Q, input, 10 bits: the coarse delay-line code from the SAR.
REQ-007 SHALL have port COMP, input, 1 bit: the PD decision; 1 means the delay is too short (increment code), 0 means too long (decrement code).
REQ-008 SHALL have port COMP_valid, input, 1 bit: one-cycle strobe qualifying COMP.
REQ-009 SHALL have port Freeze, input, 1 bit: when high, all COMP_valid strobes are ignored.
REQ-010 SHALL have port Code, output, 10 bits: the registered delay-line control code.
REQ-011 SHALL have port Track_en, output, 1 bit: high while in state TRACK.
REQ-012 SHALL have port Lock, output, 1 bit: the lock indicator.
REQ-013 SHALL have port Ovf, output, 1 bit: sticky flag set when a step is demanded beyond a code limit.

Function
REQ-014 SHALL implement FSM states IDLE and TRACK: IDLE->TRACK on SAR_done; TRACK->TRACK on SAR_done (reload); no other transitions except reset.
REQ-015 SHALL, on SAR_done in either state, register Code<=SAR_Q, acc<=0, lock counter<=0, Lock<=0 and Ovf<=0, with Code visible one cycle after the pulse.
REQ-016 SHALL, in TRACK with COMP_valid=1 and Freeze=0, update a signed accumulator acc by +1 when COMP=1 and by -1 when COMP=0.
REQ-017 SHALL, when the updated acc would reach +FILT_LEN, set Code<=Code+1 and acc<=0 in the same cycle; when it would reach -FILT_LEN, set Code<=Code-1 and acc<=0.
REQ-018 SHALL saturate Code at 0 and 1023; a step demanded beyond a limit leaves Code unchanged, clears acc and sets Ovf=1.
REQ-019 SHALL ignore COMP_valid in IDLE; Code holds its value there.
REQ-020 SHALL give SAR_done priority when SAR_done and COMP_valid coincide: the load applies and the strobe is discarded.
REQ-021 SHALL have Lock hysteresis: the lock counter increments on each accepted strobe that yields no step and clears on any step; Lock=1 when the counter reaches LOCK_CNT; once locked, Lock clears only on two consecutive steps in the same direction.
REQ-022 SHALL have the lock counter saturate at LOCK_CNT.
REQ-023 SHALL keep acc and the lock counter unchanged while Freeze=1.
REQ-024 SHALL drive Track_en combinationally from the registered state only.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=IDLE, Code=10'd512, acc=0, lock counter=0, Lock=0, Ovf=0 and Track_en=0.
REQ-026 SHALL give rst priority over SAR_done and COMP_valid; a reset mid-TRACK abandons tracking without completing a pending step.

Configuration
REQ-027 SHALL, with macro CODE_TRACKER_LOCK_DET_EN defined, include the lock counter and hysteresis logic per REQ-021..REQ-022.
REQ-028 SHALL, with CODE_TRACKER_LOCK_DET_EN undefined, tie Lock to constant 0 and omit the lock counter; all other behaviour is unchanged.

Structure
REQ-029 SHALL place in shared package code_tracker_pkg: the state enum (IDLE, TRACK), CODE_W=10, CODE_MAX=1023 and CODE_RESET=512.
REQ-030 SHALL implement the accumulator and threshold compare as one sub-module, ud_filter, producing one-cycle step_up and step_dn pulses; the FSM, code register, saturation and lock logic stay in code_tracker.

Verification
REQ-031 SHALL verify load: reset, then SAR_done with SAR_Q=300 -> Code=300 and Track_en=1 on the next cycle, with Lock=0.
REQ-032 SHALL verify filtering: Code=300, then 4 strobes with COMP=1 -> Code=301 after the 4th; 3 strobes with COMP=1 followed by 1 with COMP=0 -> Code stays 300 and acc=2.
REQ-033 SHALL verify saturation: SAR_Q=1023, then 4 strobes with COMP=1 -> Code=1023 and Ovf=1; a new SAR_done -> Ovf=0.
REQ-034 SHALL verify lock: 16 alternating strobes (COMP=1,0,...) -> Lock=1 after the 16th; then 8 strobes with COMP=0 (two down-steps) -> Lock=0.
REQ-035 SHALL verify priority: SAR_done and COMP_valid in the same cycle -> Code=SAR_Q and acc=0; rst asserted in the same cycle as a 4th up-vote -> Code=512 and state=IDLE.
REQ-036 SHALL verify freeze: Freeze=1 during 10 strobes with COMP=1 -> Code, acc and lock counter unchanged.

Source files
------------

// File: rtl/code_tracker_pkg.sv
// Shared types and constants for the delay-line code tracker.
// Lock detection is built only when CODE_TRACKER_LOCK_DET_EN is defined.
package code_tracker_pkg;

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  localparam int CODE_W     = 10;
  localparam int CODE_MAX   = 1023;
  localparam int CODE_RESET = 512;

`ifdef CODE_TRACKER_LOCK_DET_EN
  localparam bit LOCK_DET_EN = 1'b1;
`else
  localparam bit LOCK_DET_EN = 1'b0;
`endif

endpackage

// File: rtl/code_tracker_ud_filter.sv
// Up/down vote filter: a signed accumulator that emits a one-cycle step pulse
// and restarts from zero whenever the running vote reaches +/-FILT_LEN.
module ud_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic vote_en,
  input  logic vote_up,
  output logic step_up,
  output logic step_dn
);

  localparam logic signed [4:0] THR_POS = 5'(FILT_LEN);
  localparam logic signed [4:0] THR_NEG = -THR_POS;

  logic signed [4:0] acc_reg;
  logic signed [4:0] acc_sum;

  // Steps are decided from the post-vote value so the code moves on the same edge.
  always_comb begin
    acc_sum = vote_up ? (acc_reg + 5'sd1) : (acc_reg - 5'sd1);
    step_up = vote_en && (acc_sum == THR_POS);
    step_dn = vote_en && (acc_sum == THR_NEG);
  end

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      acc_reg <= '0;
    end else if (vote_en) begin
      acc_reg <= (step_up || step_dn) ? 5'sd0 : acc_sum;
    end
  end

endmodule

// File: rtl/code_tracker.sv
// Delay-line code tracker: loads the SAR result, then nudges the code from
// filtered PD votes. Lock detection is present only with CODE_TRACKER_LOCK_DET_EN.
module code_tracker
  import code_tracker_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int LOCK_CNT = 16
) (
  input  logic              CLK_exit,
  input  logic              rst,
  input  logic              SAR_done,
  input  logic [CODE_W-1:0] SAR_Q,
  input  logic              COMP,
  input  logic              COMP_valid,
  input  logic              Freeze,
  output logic [CODE_W-1:0] Code,
  output logic              Track_en,
  output logic              Lock,
  output logic              Ovf
);

  localparam logic [CODE_W-1:0] CODE_MAX_C   = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] CODE_RESET_C = CODE_W'(CODE_RESET);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("code_tracker: FILT_LEN must be within 2..15");
  end
  if (LOCK_CNT < 2 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("code_tracker: LOCK_CNT must be within 2..255");
  end

  state_t            state_reg, state_next;
  logic [CODE_W-1:0] code_reg;
  logic              ovf_reg;
  logic              vote_en, step_up, step_dn;

  always_comb begin
    state_next = state_reg;
    if (SAR_done) state_next = TRACK;
  end

  always_ff @(posedge CLK_exit) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign Track_en = (state_reg == TRACK);

  // A load in the same cycle swallows the strobe.
  assign vote_en = Track_en && COMP_valid && !Freeze && !SAR_done;

  ud_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk     (CLK_exit),
    .srst    (rst),
    .clr     (SAR_done),
    .vote_en (vote_en),
    .vote_up (COMP),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_ff @(posedge CLK_exit) begin
    if (rst) begin
      code_reg <= CODE_RESET_C;
      ovf_reg  <= 1'b0;
    end else if (SAR_done) begin
      code_reg <= SAR_Q;
      ovf_reg  <= 1'b0;
    end else if (step_up) begin
      if (code_reg == CODE_MAX_C) ovf_reg  <= 1'b1;
      else                        code_reg <= code_reg + 10'd1;
    end else if (step_dn) begin
      if (code_reg == '0) ovf_reg  <= 1'b1;
      else                code_reg <= code_reg - 10'd1;
    end
  end

  assign Code = code_reg;
  assign Ovf  = ovf_reg;

`ifdef CODE_TRACKER_LOCK_DET_EN
  localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_CNT);

  logic [7:0] lock_cnt_reg;
  logic       lock_reg;
  logic       last_valid_reg;
  logic       last_up_reg;

  // Step history restarts at lock so only post-lock steps can drop it.
  always_ff @(posedge CLK_exit) begin
    if (rst || SAR_done) begin
      lock_cnt_reg   <= '0;
      lock_reg       <= 1'b0;
      last_valid_reg <= 1'b0;
      last_up_reg    <= 1'b0;
    end else if (step_up || step_dn) begin
      lock_cnt_reg   <= '0;
      if (lock_reg && last_valid_reg && (last_up_reg == step_up)) lock_reg <= 1'b0;
      last_valid_reg <= 1'b1;
      last_up_reg    <= step_up;
    end else if (vote_en && (lock_cnt_reg != LOCK_CNT_C)) begin
      lock_cnt_reg <= lock_cnt_reg + 8'd1;
      if ((lock_cnt_reg + 8'd1) == LOCK_CNT_C) begin
        lock_reg       <= 1'b1;
        last_valid_reg <= 1'b0;
      end
    end
  end

  assign Lock = lock_reg;
`else
  assign Lock = 1'b0;
`endif

endmodule
